// File: rtl/gray_pkg.sv
// Shared Gray-code definitions: FSM state encoding and Gray-to-binary conversion.
// Used by both the receive decoder and the encoder side of the Gray counter.
package gray_pkg;

    localparam int unsigned GRAY_MAX_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } gray_state_e;

    // Prefix XOR from the MSB down; a zero-extended narrower code converts correctly.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_in_filter.sv
// Synchronizer plus stability filter for an asynchronous Gray-coded bus.
// Ports:
//   clk, reset   clock, synchronous active-low reset
//   gray_in      asynchronous N-bit Gray input
//   cand         current candidate code (last synchronized value seen)
//   accept       1-cycle pulse, cand has been stable for STABLE_CYCLES samples
module gray_in_filter #(
    parameter int unsigned N             = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] gray_in,
    output logic [N-1:0] cand,
    output logic         accept
);

    localparam int unsigned   CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic          ONE_SHOT = (STABLE_CYCLES == 1);

    logic [N-1:0]     sync_q [SYNC_STAGES];
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [N-1:0]     s;

    assign s       = sync_q[SYNC_STAGES-1];
    assign cnt_inc = cnt + CNT_W'(1);

    // Synchronizer chain
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Stability counter; accept fires once, on the edge the count reaches its limit
    always_ff @(posedge clk) begin
        if (!reset) begin
            cand   <= '0;
            cnt    <= '0;
            accept <= 1'b0;
        end else if (s != cand) begin
            cand   <= s;
            cnt    <= CNT_W'(1);
            accept <= ONE_SHOT;
        end else if (cnt != CNT_MAX) begin
            cnt    <= cnt_inc;
            accept <= (cnt_inc == CNT_MAX);
        end else begin
            accept <= 1'b0;
        end
    end

endmodule

// File: rtl/gray_rx_decoder.sv
// Gray counter receiver: filters an asynchronous Gray input, decodes it and
// classifies every accepted change as step up, step down or illegal skip.
// Ports:
//   clk, reset   clock, synchronous active-low reset
//   gray_in      asynchronous N-bit Gray input
//   clr          synchronous clear of position and err_count
//   bin_out      binary value of last accepted code
//   valid        high while tracking is locked
//   step_up, step_down, err_skip   1-cycle classification pulses
//   position     signed running step count (wraps)
//   err_count    skip-error count, saturating at 255
module gray_rx_decoder
    import gray_pkg::*;
#(
    parameter int unsigned N             = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned POS_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     gray_in,
    input  logic             clr,
    output logic [N-1:0]     bin_out,
    output logic             valid,
    output logic             step_up,
    output logic             step_down,
    output logic             err_skip,
    output logic [POS_W-1:0] position,
    output logic [7:0]       err_count
);

    localparam int unsigned ERR_W   = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic [N-1:0] cand;
    logic         accept;

    gray_in_filter #(
        .N             (N),
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk     (clk),
        .reset   (reset),
        .gray_in (gray_in),
        .cand    (cand),
        .accept  (accept)
    );

    gray_state_e      state_q, state_d;
    logic [N-1:0]     b_c;
    logic             is_up_c, is_dn_c;
    logic [N-1:0]     bin_d;
    logic             up_d, dn_d, skip_d, valid_d;
    logic [POS_W-1:0] pos_d;
    logic [ERR_W-1:0] err_d;

    assign b_c     = N'(gray2bin(GRAY_MAX_W'(cand)));
    assign is_up_c = (b_c == N'(bin_out + N'(1)));
    assign is_dn_c = (b_c == N'(bin_out - N'(1)));

    // Next-state and next-output logic; bin_out doubles as the previous reference
    always_comb begin
        state_d = state_q;
        bin_d   = bin_out;
        up_d    = 1'b0;
        dn_d    = 1'b0;
        skip_d  = 1'b0;
        pos_d   = position;
        err_d   = err_count;

        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    bin_d   = b_c;
                    state_d = ST_TRACK;
                end
                ST_TRACK, ST_FAULT: begin
                    // A glitch that returns to the old code re-accepts it; treat as no change
                    if (b_c != bin_out) begin
                        bin_d = b_c;
                        if (is_up_c) begin
                            up_d    = 1'b1;
                            pos_d   = position + POS_W'(1);
                            state_d = ST_TRACK;
                        end else if (is_dn_c) begin
                            dn_d    = 1'b1;
                            pos_d   = position - POS_W'(1);
                            state_d = ST_TRACK;
                        end else begin
                            skip_d  = 1'b1;
                            err_d   = (err_count == ERR_MAX) ? err_count : err_count + ERR_W'(1);
                            state_d = ST_FAULT;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (clr) begin
            pos_d = '0;
            err_d = '0;
        end

        valid_d = (state_d == ST_TRACK);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            bin_out   <= '0;
            valid     <= 1'b0;
            step_up   <= 1'b0;
            step_down <= 1'b0;
            err_skip  <= 1'b0;
            position  <= '0;
            err_count <= '0;
        end else begin
            state_q   <= state_d;
            bin_out   <= bin_d;
            valid     <= valid_d;
            step_up   <= up_d;
            step_down <= dn_d;
            err_skip  <= skip_d;
            position  <= pos_d;
            err_count <= err_d;
        end
    end

endmodule
